// File: rtl/rv_pipe_pkg.sv
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared types and constants for the RV pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    // Wide enough for the largest legal FWD_DEPTH (4); ports truncate to their width.
    localparam int FWD_SEL_MAX_W = 3;
    typedef logic [FWD_SEL_MAX_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_SEL_REGFILE = '0;

endpackage

`default_nettype wire

// File: rtl/rv_fwd_tracker.sv
// ============================================================================
// Module      : rv_fwd_tracker
// Description : Tracks the destinations of in-flight results and picks the
//               youngest matching slot for each ID-stage source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_fwd_tracker
    import rv_pipe_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int RADDR_W   = 5,
    parameter int SEL_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_shift,
    input  logic               i_bubble,
    input  logic               i_ex_wen,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic               i_ex_is_load,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_rs1_used,
    input  logic               i_id_rs2_used,
    output logic [SEL_W-1:0]   o_fwd_sel_rs1,
    output logic [SEL_W-1:0]   o_fwd_sel_rs2
);

    logic [FWD_DEPTH:1] w_vld;
    logic [RADDR_W-1:0] w_rd [1:FWD_DEPTH];
    fwd_sel_t           w_sel1;
    fwd_sel_t           w_sel2;

    assign w_vld[1] = i_ex_wen;
    assign w_rd[1]  = i_ex_rd;

    // Slots 2..FWD_DEPTH are registered copies of the slot behind them.
    for (genvar k = 2; k <= FWD_DEPTH; k++) begin : g_slot
        logic               w_src_vld;
        logic [RADDR_W-1:0] r_rd;
        logic               r_vld;

        if (k == 2) begin : g_head
            assign w_src_vld = i_ex_wen & ~i_bubble;
        end else begin : g_body
            assign w_src_vld = w_vld[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_rd  <= '0;
            end else if (i_shift) begin
                r_vld <= w_src_vld;
                r_rd  <= w_rd[k-1];
            end
        end

        assign w_vld[k] = r_vld;
        assign w_rd[k]  = r_rd;
    end

    // Scan oldest to youngest so the lowest-index match wins.
    always_comb begin
        w_sel1 = FWD_SEL_REGFILE;
        w_sel2 = FWD_SEL_REGFILE;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (w_vld[k] && !(k == 1 && i_ex_is_load)) begin
                if (i_id_rs1_used && (i_id_rs1 != '0) && (w_rd[k] == i_id_rs1))
                    w_sel1 = fwd_sel_t'(k);
                if (i_id_rs2_used && (i_id_rs2 != '0) && (w_rd[k] == i_id_rs2))
                    w_sel2 = fwd_sel_t'(k);
            end
        end
    end

    assign o_fwd_sel_rs1 = SEL_W'(w_sel1);
    assign o_fwd_sel_rs2 = SEL_W'(w_sel2);

endmodule

`default_nettype wire

// File: rtl/rv_pipe_ctrl.sv
// ============================================================================
// Module      : rv_pipe_ctrl
// Description : Pipeline controller: jump redirect/flush, load-use interlock,
//               operand forwarding select and data-memory wait with timeout.
//               Define RV_PIPE_PERF_EN to add saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int JUMP_STAGE  = 2,
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int FWD_DEPTH   = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_jump_en_ex,
    input  logic [XLEN-1:0]                i_jump_addr_ex,
    input  logic [RADDR_W-1:0]             i_id_rs1,
    input  logic [RADDR_W-1:0]             i_id_rs2,
    input  logic                           i_id_rs1_used,
    input  logic                           i_id_rs2_used,
    input  logic [RADDR_W-1:0]             i_ex_rd,
    input  logic                           i_ex_reg_wen,
    input  logic                           i_ex_is_load,
    input  logic                           i_mem_req,
    input  logic                           i_mem_ready,
    output logic                           o_jump,
    output logic [XLEN-1:0]                o_jump_addr,
    output logic [NUM_STAGES-1:0]          o_stall_n,
    output logic [NUM_STAGES-1:0]          o_flush,
    output logic [$clog2(FWD_DEPTH+1)-1:0] o_fwd_sel_rs1,
    output logic [$clog2(FWD_DEPTH+1)-1:0] o_fwd_sel_rs2,
`ifdef RV_PIPE_PERF_EN
    output logic [31:0]                    o_perf_stall_cnt,
    output logic [31:0]                    o_perf_flush_cnt,
    output logic [31:0]                    o_perf_memwait_cnt,
`endif
    output logic                           o_mem_err
);

    localparam int SEL_W = $clog2(FWD_DEPTH+1);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT+1) : 1;

    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mem_err;
    logic                  w_run;
    logic                  w_jump;
    logic                  w_load_use;
    logic                  w_timeout;
    logic [NUM_STAGES-1:0] w_stall_n;
    logic [NUM_STAGES-1:0] w_flush;
    logic [SEL_W-1:0]      w_sel_rs1;
    logic [SEL_W-1:0]      w_sel_rs2;

    assign w_run  = (r_state == RUN);
    assign w_jump = w_run & i_jump_en_ex;

    // Jump outranks the interlock: the dependent ID instruction is flushed anyway.
    assign w_load_use = w_run & ~i_jump_en_ex & i_ex_is_load & i_ex_reg_wen &
                        (i_ex_rd != '0) &
                        ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                         (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

    if (MEM_TIMEOUT > 0) begin : g_timeout
        assign w_timeout = (r_state == MEM_WAIT) & ~i_mem_ready &
                           (r_cnt == CNT_W'(MEM_TIMEOUT-1));
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (i_mem_req && !i_mem_ready) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (i_mem_ready || w_timeout)  w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end

    // A timed-out access leaves EX on the first RUN cycle; that register loads a bubble.
    always_comb begin
        w_stall_n = '1;
        w_flush   = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (w_jump && i >= 1 && i <= JUMP_STAGE) w_flush[i]   = 1'b1;
            if (w_load_use && i < JUMP_STAGE)        w_stall_n[i] = 1'b0;
            if (w_load_use && i == JUMP_STAGE)       w_flush[i]   = 1'b1;
            if (r_mem_err && i == JUMP_STAGE + 1)    w_flush[i]   = 1'b1;
        end
        if (r_state == MEM_WAIT) begin
            w_stall_n = '0;
            w_flush   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_err <= w_timeout;
            if (r_state == MEM_WAIT && w_state_nxt == MEM_WAIT)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    rv_fwd_tracker #(
        .FWD_DEPTH (FWD_DEPTH),
        .RADDR_W   (RADDR_W),
        .SEL_W     (SEL_W)
    ) u_fwd_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_shift       (w_run),
        .i_bubble      (r_mem_err),
        .i_ex_wen      (i_ex_reg_wen),
        .i_ex_rd       (i_ex_rd),
        .i_ex_is_load  (i_ex_is_load),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .o_fwd_sel_rs1 (w_sel_rs1),
        .o_fwd_sel_rs2 (w_sel_rs2)
    );

    // Outputs are forced to their idle values while reset is asserted.
    assign o_jump        = rst_n & w_jump;
    assign o_jump_addr   = o_jump ? i_jump_addr_ex : '0;
    assign o_stall_n     = rst_n ? w_stall_n : '1;
    assign o_flush       = rst_n ? w_flush : '0;
    assign o_fwd_sel_rs1 = rst_n ? w_sel_rs1 : '0;
    assign o_fwd_sel_rs2 = rst_n ? w_sel_rs2 : '0;
    assign o_mem_err     = r_mem_err;

`ifdef RV_PIPE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_memwait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
            r_perf_memwait <= '0;
        end else begin
            if (w_load_use && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_jump && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + 32'd1;
            if (r_state == MEM_WAIT && r_perf_memwait != '1)
                r_perf_memwait <= r_perf_memwait + 32'd1;
        end
    end

    assign o_perf_stall_cnt   = r_perf_stall;
    assign o_perf_flush_cnt   = r_perf_flush;
    assign o_perf_memwait_cnt = r_perf_memwait;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_pipe_ctrl.sv
// ============================================================================
// Module      : tb_rv_pipe_ctrl
// Description : Directed self-checking bench for rv_pipe_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en_ex;
    logic [31:0] jump_addr_ex;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_reg_wen, ex_is_load;
    logic        mem_req, mem_ready;
    logic        jump;
    logic [31:0] jump_addr;
    logic [2:0]  stall_n, flush;
    logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic        mem_err;
`ifdef RV_PIPE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int err_seen;

    always #5 clk = ~clk;

    rv_pipe_ctrl #(
        .NUM_STAGES  (3),
        .JUMP_STAGE  (2),
        .XLEN        (32),
        .RADDR_W     (5),
        .FWD_DEPTH   (2),
        .MEM_TIMEOUT (4)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_jump_en_ex       (jump_en_ex),
        .i_jump_addr_ex     (jump_addr_ex),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_id_rs1_used      (id_rs1_used),
        .i_id_rs2_used      (id_rs2_used),
        .i_ex_rd            (ex_rd),
        .i_ex_reg_wen       (ex_reg_wen),
        .i_ex_is_load       (ex_is_load),
        .i_mem_req          (mem_req),
        .i_mem_ready        (mem_ready),
        .o_jump             (jump),
        .o_jump_addr        (jump_addr),
        .o_stall_n          (stall_n),
        .o_flush            (flush),
        .o_fwd_sel_rs1      (fwd_sel_rs1),
        .o_fwd_sel_rs2      (fwd_sel_rs2),
`ifdef RV_PIPE_PERF_EN
        .o_perf_stall_cnt   (perf_stall_cnt),
        .o_perf_flush_cnt   (perf_flush_cnt),
        .o_perf_memwait_cnt (perf_memwait_cnt),
`endif
        .o_mem_err          (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump_en_ex   = 1'b0;
        jump_addr_ex = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        ex_rd        = '0;
        ex_reg_wen   = 1'b0;
        ex_is_load   = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        jump_en_ex   = 1'b1;
        jump_addr_ex = 32'h0000_0100;
        #12;
        chk("rst_stall_n",   64'(stall_n),     64'h7);
        chk("rst_flush",     64'(flush),       64'h0);
        chk("rst_jump",      64'(jump),        64'h0);
        chk("rst_jump_addr", 64'(jump_addr),   64'h0);
        chk("rst_fwd1",      64'(fwd_sel_rs1), 64'h0);
        chk("rst_mem_err",   64'(mem_err),     64'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Jump redirect
        jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0100;
        #1;
        chk("jmp_jump",    64'(jump),      64'h1);
        chk("jmp_addr",    64'(jump_addr), 64'h100);
        chk("jmp_flush",   64'(flush),     64'h6);
        chk("jmp_stall_n", 64'(stall_n),   64'h7);
        tick();

        // Jump together with a load-use hazard: jump wins
        jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0200;
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        chk("jmplu_stall_n", 64'(stall_n), 64'h7);
        chk("jmplu_flush",   64'(flush),   64'h6);
        idle(2);

        // Load-use interlock, then forwarding from slot 2
        ex_is_load = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        chk("lu_stall_n", 64'(stall_n),     64'h4);
        chk("lu_flush",   64'(flush),       64'h4);
        chk("lu_fwd1",    64'(fwd_sel_rs1), 64'h0);
        tick();
        ex_is_load = 1'b0; ex_reg_wen = 1'b0; ex_rd = 5'd0;
        #1;
        chk("lu2_stall_n", 64'(stall_n),     64'h7);
        chk("lu2_flush",   64'(flush),       64'h0);
        chk("lu2_fwd1",    64'(fwd_sel_rs1), 64'h2);
        idle(2);

        // Forwarding from EX, x0 and unused sources never forward
        ex_reg_wen = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        id_rs1 = 5'd7; id_rs1_used = 1'b0;
        #1;
        chk("fwd_ex_rs2",     64'(fwd_sel_rs2), 64'h1);
        chk("fwd_unused_rs1", 64'(fwd_sel_rs1), 64'h0);
        chk("fwd_ex_stall",   64'(stall_n),     64'h7);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("fwd_x0_rs2", 64'(fwd_sel_rs2), 64'h0);
        ex_rd = 5'd7; id_rs2 = 5'd7;
        tick();
        #1;
        chk("fwd_prio_rs2", 64'(fwd_sel_rs2), 64'h1);
        ex_reg_wen = 1'b0;
        #1;
        chk("fwd_slot2_rs2", 64'(fwd_sel_rs2), 64'h2);
        idle(2);

        // Zero-wait access: no stall
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("mem0_stall_n", 64'(stall_n), 64'h7);
        tick();
        mem_req = 1'b0;
        #1;
        chk("mem0_after", 64'(stall_n), 64'h7);
        idle(1);

        // Multi-cycle access: three MEM_WAIT cycles, jump ignored while waiting
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("memw_req_cycle", 64'(stall_n), 64'h7);
        tick();
        jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0300;
        #1;
        chk("memw1_stall_n", 64'(stall_n), 64'h0);
        chk("memw1_jump",    64'(jump),    64'h0);
        chk("memw1_flush",   64'(flush),   64'h0);
        tick();
        jump_en_ex = 1'b0;
        #1;
        chk("memw2_stall_n", 64'(stall_n), 64'h0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("memw3_stall_n", 64'(stall_n), 64'h0);
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("memw_done_stall_n", 64'(stall_n), 64'h7);
        chk("memw_done_err",     64'(mem_err), 64'h0);
        idle(1);

        // Timeout after 4 wait cycles: exactly one mem_err pulse
        err_seen = 0;
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_wait%0d_stall_n", i), 64'(stall_n), 64'h0);
            if (mem_err) err_seen++;
            tick();
        end
        #1;
        chk("to_err_pulse", 64'(mem_err), 64'h1);
        chk("to_run",       64'(stall_n), 64'h7);
        if (mem_err) err_seen++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_err) err_seen++;
        end
        chk("to_err_count", 64'(err_seen), 64'd1);

        // Reset in the middle of MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        mem_req = 1'b0;
        #1;
        chk("rstw_in_wait", 64'(stall_n), 64'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_stall_n", 64'(stall_n), 64'h7);
        chk("rstw_mem_err", 64'(mem_err), 64'h0);
`ifdef RV_PIPE_PERF_EN
        chk("rstw_perf_stall",   64'(perf_stall_cnt),   64'h0);
        chk("rstw_perf_flush",   64'(perf_flush_cnt),   64'h0);
        chk("rstw_perf_memwait", 64'(perf_memwait_cnt), 64'h0);
`endif
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        err_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_err) err_seen++;
        end
        chk("rstw_run",    64'(stall_n),  64'h7);
        chk("rstw_no_err", 64'(err_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
